// File: rtl/bayes_decider_pkg.sv
// Shared types and constants for the Bayesian posterior decider.
package bayes_decider_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StScan,
        StDone
    } state_e;

    localparam logic MODE_STOCH = 1'b0;
    localparam logic MODE_LOG   = 1'b1;

endpackage

// File: rtl/score_scan.sv
// Sequential compare-and-select over one score per cycle; keeps the running best.
module score_scan
    import bayes_decider_pkg::*;
#(
    parameter int unsigned IdxW   = 2,
    parameter int unsigned ScoreW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              first_i,
    input  logic              mode_i,
    input  logic [IdxW-1:0]   idx_i,
    input  logic [ScoreW-1:0] score_i,
    output logic [IdxW-1:0]   sel_idx_o,
    output logic [ScoreW-1:0] sel_score_o
);

    logic [IdxW-1:0]   best_idx_q, best_idx_d;
    logic [ScoreW-1:0] best_score_q, best_score_d;
    logic              better;

    // Strict compare so an equal score never displaces an earlier (lower) index.
    always_comb begin
        better = (mode_i == MODE_LOG) ? (score_i < best_score_q) : (score_i > best_score_q);
        if (first_i || better) begin
            sel_idx_o   = idx_i;
            sel_score_o = score_i;
        end else begin
            sel_idx_o   = best_idx_q;
            sel_score_o = best_score_q;
        end
        best_idx_d   = en_i ? sel_idx_o : best_idx_q;
        best_score_d = en_i ? sel_score_o : best_score_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_idx_q   <= '0;
            best_score_q <= '0;
        end else begin
            best_idx_q   <= best_idx_d;
            best_score_q <= best_score_d;
        end
    end

endmodule

// File: rtl/bayes_posterior_decider.sv
// Accumulates per-row stochastic counts or serial log scores, then scans rows
// to report the MAP row index with a one-cycle done pulse.
module bayes_posterior_decider
    import bayes_decider_pkg::*;
#(
    parameter int unsigned Narray = 2,
    parameter int unsigned CNTW   = 16,
    parameter int unsigned LOGW   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stoch_log,
    input  logic [CNTW-1:0]      n_samples,
    input  logic                 valid_in,
    input  logic [2**Narray-1:0] bit_in,
    output logic                 busy,
    output logic                 done,
    output logic [Narray-1:0]    winner,
    output logic [CNTW-1:0]      winner_score
);

    localparam int unsigned NROW = 2 ** Narray;
    localparam logic [Narray-1:0] LastRow = Narray'(NROW - 1);

    if (LOGW > CNTW) begin : g_logw_check
        $error("LOGW must not exceed CNTW");
    end

    state_e            state_q, state_d;
    logic              mode_q, mode_d;
    logic [CNTW-1:0]   t_q, t_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [Narray-1:0] s_q, s_d;
    logic [CNTW-1:0]   acc_q [NROW];
    logic [CNTW-1:0]   acc_d [NROW];
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [Narray-1:0] winner_q, winner_d;
    logic [CNTW-1:0]   score_q, score_d;

    logic [CNTW-1:0]   t_new;
    logic [CNTW-1:0]   cnt_inc;
    logic [Narray-1:0] sel_idx;
    logic [CNTW-1:0]   sel_score;

    score_scan #(
        .IdxW   (Narray),
        .ScoreW (CNTW)
    ) u_scan (
        .clk         (clk),
        .rst         (rst),
        .en_i        (state_q == StScan),
        .first_i     (s_q == '0),
        .mode_i      (mode_q),
        .idx_i       (s_q),
        .score_i     (acc_q[s_q]),
        .sel_idx_o   (sel_idx),
        .sel_score_o (sel_score)
    );

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        t_d      = t_q;
        cnt_d    = cnt_q;
        s_d      = s_q;
        acc_d    = acc_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        winner_d = winner_q;
        score_d  = score_q;
        t_new    = (stoch_log == MODE_LOG) ? CNTW'(LOGW) : n_samples;
        cnt_inc  = cnt_q + 1'b1;

        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                if (start) begin
                    for (int r = 0; r < NROW; r++) begin
                        acc_d[r] = '0;
                    end
                    cnt_d    = '0;
                    s_d      = '0;
                    winner_d = '0;
                    score_d  = '0;
                    mode_d   = stoch_log;
                    t_d      = t_new;
                    busy_d   = 1'b1;
                    state_d  = (t_new == '0) ? StScan : StAccum;
                end
            end
            StAccum: begin
                if (valid_in) begin
                    cnt_d = cnt_inc;
                    for (int r = 0; r < NROW; r++) begin
                        if (mode_q == MODE_LOG) begin
                            // Beat k carries bit k of the LSB-first log word.
                            acc_d[r] = acc_q[r] | (CNTW'(bit_in[r]) << cnt_q);
                        end else if (bit_in[r] && (acc_q[r] != '1)) begin
                            acc_d[r] = acc_q[r] + 1'b1;
                        end
                    end
                    if (cnt_inc == t_q) begin
                        state_d = StScan;
                        s_d     = '0;
                    end
                end
            end
            StScan: begin
                if (s_q == LastRow) begin
                    state_d  = StDone;
                    done_d   = 1'b1;
                    winner_d = sel_idx;
                    score_d  = sel_score;
                end else begin
                    s_d = s_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            mode_q   <= MODE_STOCH;
            t_q      <= '0;
            cnt_q    <= '0;
            s_q      <= '0;
            for (int r = 0; r < NROW; r++) begin
                acc_q[r] <= '0;
            end
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            winner_q <= '0;
            score_q  <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            t_q      <= t_d;
            cnt_q    <= cnt_d;
            s_q      <= s_d;
            acc_q    <= acc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            winner_q <= winner_d;
            score_q  <= score_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign winner       = winner_q;
    assign winner_score = score_q;

endmodule

// File: tb/tb_bayes_posterior_decider.sv
// Randomised self-checking bench for bayes_posterior_decider against a score/argmax model.
module tb_bayes_posterior_decider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start_s;
    logic        stoch_log;
    logic [15:0] n_samples;
    logic [3:0]  n_samples_s;
    logic        valid_in;
    logic [3:0]  bit_in;
    logic        busy, done, busy_s, done_s;
    logic [1:0]  winner, winner_s;
    logic [15:0] winner_score;
    logic [3:0]  winner_score_s;

    int cyc = 0;
    int passed = 0;
    int total = 0;
    logic [3:0] beats[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bayes_posterior_decider #(.Narray(2), .CNTW(16), .LOGW(8)) dut (
        .clk (clk), .rst (rst), .start (start), .stoch_log (stoch_log),
        .n_samples (n_samples), .valid_in (valid_in), .bit_in (bit_in),
        .busy (busy), .done (done), .winner (winner), .winner_score (winner_score)
    );

    bayes_posterior_decider #(.Narray(2), .CNTW(4), .LOGW(4)) dut_s (
        .clk (clk), .rst (rst), .start (start_s), .stoch_log (1'b0),
        .n_samples (n_samples_s), .valid_in (valid_in), .bit_in (bit_in),
        .busy (busy_s), .done (done_s), .winner (winner_s), .winner_score (winner_score_s)
    );

    // Reference: per-row score from the first t beats, then first-index argmax/argmin.
    function automatic void model(input logic mode, input int t, input int maxv,
                                  output int w, output int sc);
        int acc[4];
        for (int r = 0; r < 4; r++) acc[r] = 0;
        for (int k = 0; k < t && k < beats.size(); k++) begin
            for (int r = 0; r < 4; r++) begin
                if (mode) acc[r] += int'(beats[k][r]) << k;
                else if (beats[k][r] && acc[r] < maxv) acc[r]++;
            end
        end
        w = 0;
        sc = acc[0];
        for (int r = 1; r < 4; r++) begin
            if (mode ? (acc[r] < sc) : (acc[r] > sc)) begin
                w = r;
                sc = acc[r];
            end
        end
    endfunction

    task automatic run(input logic mode, input logic [15:0] ns, input int gap,
                       output int c_last, output int c_done, output logic busy_seen,
                       output bit to);
        @(negedge clk);
        start = 1'b1; stoch_log = mode; n_samples = ns;
        c_last = cyc;
        @(negedge clk);
        start = 1'b0;
        busy_seen = busy;
        for (int i = 0; i < beats.size(); i++) begin
            for (int g = 0; g < gap; g++) begin
                valid_in = 1'b0; bit_in = 4'($urandom);
                @(negedge clk);
            end
            valid_in = 1'b1; bit_in = beats[i]; c_last = cyc;
            @(negedge clk);
        end
        valid_in = 1'b0;
        to = 1'b1;
        c_done = -1;
        for (int k = 0; k < 60; k++) begin
            if (done) begin
                c_done = cyc; to = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 0; start_s = 0; stoch_log = 0; n_samples = 0; n_samples_s = 0;
        valid_in = 0; bit_in = 0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, winner, winner_score} !== 20'h0) $display("FAIL reset_main got %h want 0",
            {busy, done, winner, winner_score});
        else passed++;
        total++;
        if ({busy_s, done_s, winner_s, winner_score_s} !== 8'h0) $display("FAIL reset_sat got %h want 0",
            {busy_s, done_s, winner_s, winner_score_s});
        else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_run(input string name, input logic mode, input int t, input int c_last,
                             input int c_done, input logic busy_seen, input bit to);
        int w, sc;
        model(mode, t, 65535, w, sc);
        total++;
        if (to) $display("FAIL %s_timeout no done within bound", name);
        else if (c_done !== c_last + 5) $display("FAIL %s_latency got %0d want %0d", name,
            c_done - c_last, 5);
        else passed++;
        total++;
        if (winner !== 2'(w)) $display("FAIL %s_winner got %0d want %0d", name, winner, w);
        else passed++;
        total++;
        if (winner_score !== 16'(sc)) $display("FAIL %s_score got %0d want %0d", name,
            winner_score, sc);
        else passed++;
        total++;
        if (busy_seen !== 1'b1) $display("FAIL %s_busy got %b want 1", name, busy_seen);
        else passed++;
    endtask

    task automatic test_stoch_fixed;
        int cl, cd; logic b; bit to;
        beats.delete();
        repeat (10) beats.push_back(4'b0101);
        run(1'b0, 16'd10, 0, cl, cd, b, to);
        total++;
        if (winner !== 2'd0 || winner_score !== 16'd10) $display("FAIL stoch_fixed got %0d/%0d want 0/10",
            winner, winner_score);
        else passed++;
        check_run("stoch_fixed", 1'b0, 10, cl, cd, b, to);
    endtask

    task automatic test_log_fixed;
        int cl, cd; logic b; bit to;
        logic [7:0] words [4];
        words[0] = 8'h40; words[1] = 8'h12; words[2] = 8'h12; words[3] = 8'hFF;
        beats.delete();
        for (int k = 0; k < 8; k++)
            beats.push_back({words[3][k], words[2][k], words[1][k], words[0][k]});
        run(1'b1, 16'd3, 0, cl, cd, b, to);
        total++;
        if (winner !== 2'd1 || winner_score !== 16'h0012) $display("FAIL log_fixed got %0d/%h want 1/0012",
            winner, winner_score);
        else passed++;
        check_run("log_fixed", 1'b1, 8, cl, cd, b, to);
    endtask

    task automatic test_gapped;
        int cl, cd; logic b; bit to;
        beats.delete();
        repeat (6) beats.push_back(4'b0100);
        run(1'b0, 16'd6, 2, cl, cd, b, to);
        total++;
        if (winner !== 2'd2 || winner_score !== 16'd6) $display("FAIL gapped got %0d/%0d want 2/6",
            winner, winner_score);
        else passed++;
        check_run("gapped", 1'b0, 6, cl, cd, b, to);
    endtask

    task automatic test_zero_b2b;
        logic [11:0] d_hist, b_hist;
        logic [1:0]  w0;
        logic [17:0] ws4;
        @(negedge clk);
        start = 1'b1; stoch_log = 1'b0; n_samples = 16'd0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            d_hist[k] = done; b_hist[k] = busy;
            if (k == 0) w0 = winner;
            if (k == 4) ws4 = {winner, winner_score};
            if (k == 5) start = 1'b0;
        end
        total++;
        if (d_hist !== 12'b0010_0001_0000) $display("FAIL zero_done got %b want %b", d_hist,
            12'b0010_0001_0000);
        else passed++;
        total++;
        if (b_hist !== 12'b0011_1111_1111) $display("FAIL b2b_busy got %b want %b", b_hist,
            12'b0011_1111_1111);
        else passed++;
        total++;
        if (w0 !== 2'd0) $display("FAIL start_clears_winner got %0d want 0", w0);
        else passed++;
        total++;
        if (ws4 !== 18'd0) $display("FAIL zero_result got %h want 0", ws4);
        else passed++;
    endtask

    task automatic test_random;
        int cl, cd; logic b; bit to;
        logic mode; int t; int gap;
        logic [7:0] words [4];
        for (int it = 0; it < 10; it++) begin
            mode = 1'($urandom);
            gap = $urandom_range(0, 2);
            beats.delete();
            if (mode) begin
                for (int r = 0; r < 4; r++)
                    words[r] = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
                for (int k = 0; k < 8; k++)
                    beats.push_back({words[3][k], words[2][k], words[1][k], words[0][k]});
                t = 8;
            end else begin
                t = $urandom_range(1, 20);
                for (int k = 0; k < t; k++) beats.push_back(4'($urandom));
            end
            run(mode, mode ? 16'($urandom_range(0, 40)) : 16'(t), gap, cl, cd, b, to);
            check_run($sformatf("random%0d", it), mode, t, cl, cd, b, to);
        end
    endtask

    task automatic test_saturation;
        int w, sc, cl, cd;
        logic [1:0] wd; logic [3:0] sd;
        beats.delete();
        for (int k = 0; k < 15; k++) beats.push_back({1'b1, 3'($urandom)});
        model(1'b0, 15, 15, w, sc);
        @(negedge clk);
        start_s = 1'b1; n_samples_s = 4'd15;
        @(negedge clk);
        start_s = 1'b0;
        cl = cyc;
        for (int k = 0; k < 15; k++) begin
            valid_in = 1'b1; bit_in = beats[k]; cl = cyc;
            @(negedge clk);
        end
        cd = -1; wd = 0; sd = 0;
        for (int k = 0; k < 10; k++) begin
            valid_in = 1'b1; bit_in = 4'hF;
            if (done_s && cd < 0) begin
                cd = cyc; wd = winner_s; sd = winner_score_s;
            end
            @(negedge clk);
        end
        valid_in = 1'b0;
        total++;
        if (cd !== cl + 5) $display("FAIL sat_latency got %0d want %0d", cd - cl, 5);
        else passed++;
        total++;
        if (wd !== 2'(w) || sd !== 4'd15) $display("FAIL sat_result got %0d/%0d want %0d/15", wd, sd, w);
        else passed++;
        total++;
        if (winner_s !== 2'(w) || winner_score_s !== 4'd15 || busy_s !== 1'b0)
            $display("FAIL sat_extra_ignored got %0d/%0d busy %b want %0d/15 busy 0",
                winner_s, winner_score_s, busy_s, w);
        else passed++;
    endtask

    task automatic test_reset_mid;
        int cl, cd; logic b; bit to;
        @(negedge clk);
        start = 1'b1; stoch_log = 1'b0; n_samples = 16'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (4) begin
            valid_in = 1'b1; bit_in = 4'b1111;
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({busy, done, winner, winner_score} !== 20'h0) $display("FAIL reset_mid got %h want 0",
            {busy, done, winner, winner_score});
        else passed++;
        @(negedge clk);
        rst = 1'b0; valid_in = 1'b0;
        beats.delete();
        repeat (4) beats.push_back(4'b0010);
        run(1'b0, 16'd4, 0, cl, cd, b, to);
        total++;
        if (winner !== 2'd1 || winner_score !== 16'd4) $display("FAIL after_reset got %0d/%0d want 1/4",
            winner, winner_score);
        else passed++;
        check_run("after_reset", 1'b0, 4, cl, cd, b, to);
    endtask

    initial begin
        test_reset();
        test_stoch_fixed();
        test_log_fixed();
        test_gapped();
        test_zero_b2b();
        test_random();
        test_saturation();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
